// File: rtl/sublime_i2s_tx_pkg.sv
// rtl/sublime_i2s_tx_pkg.sv - shared I2S frame geometry, FSM states and slot packing helper
package sublime_i2s_tx_pkg;

  localparam int I2S_FRAME_BITS = 64;
  localparam int I2S_SLOT_BITS  = 32;
  localparam int BIT_CNT_W      = $clog2(I2S_FRAME_BITS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_e;

  // Keep the top 'bits' MSBs of a slot and zero the remaining tail bits.
  function automatic logic [I2S_SLOT_BITS-1:0] slot_word(input logic [I2S_SLOT_BITS-1:0] s,
                                                        input int bits);
    logic [I2S_SLOT_BITS-1:0] tail_mask;
    tail_mask = (I2S_SLOT_BITS'(1) << (I2S_SLOT_BITS - bits)) - I2S_SLOT_BITS'(1);
    return s & ~tail_mask;
  endfunction

endpackage

// File: rtl/sublime_i2s_bclk_gen.sv
// rtl/sublime_i2s_bclk_gen.sv - BCLK divider producing the bit clock and its falling-edge strobe
module sublime_i2s_bclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic bclk_o,
  output logic fall_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          term;

  assign term   = en_i && (div_cnt_q == DIV_LAST);
  assign fall_o = term && bclk_q;
  assign bclk_o = bclk_q;

  // Disabled means parked at the reset values so a restart always begins on a low BCLK.
  always_comb begin
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    if (!en_i) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (term) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

endmodule

// File: rtl/sublime_i2s_tx.sv
// rtl/sublime_i2s_tx.sv - stereo I2S serialiser: frame FSM, bit counter, shift register, sample request
module sublime_i2s_tx
  import sublime_i2s_tx_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int SAMPLE_BITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] left_sample,
  input  logic [31:0] right_sample,
  output logic        sample_req,
  output logic        busy,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata
);

  localparam logic [BIT_CNT_W-1:0] CNT_LAST = BIT_CNT_W'(I2S_FRAME_BITS - 1);

  i2s_state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]       bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic [I2S_FRAME_BITS-1:0]  shift_q, shift_d;
  logic                       lrclk_q, lrclk_d;
  logic                       sdata_q, sdata_d;
  logic                       req_q, req_d;
  logic                       run, fall, wrap;

  assign run         = (state_q == ST_RUN);
  assign wrap        = fall && (bit_cnt_q == CNT_LAST);
  assign bit_cnt_inc = bit_cnt_q + BIT_CNT_W'(1);

  sublime_i2s_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (run),
    .bclk_o (i2s_bclk),
    .fall_o (fall)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    req_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wrap && !enable) begin
          state_d   = ST_IDLE;
          bit_cnt_d = CNT_LAST;
          shift_d   = '0;
          lrclk_d   = 1'b0;
          sdata_d   = 1'b0;
        end else if (fall) begin
          // The wrap fall still emits the previous frame's last right bit before the reload.
          bit_cnt_d = bit_cnt_inc;
          lrclk_d   = bit_cnt_inc[BIT_CNT_W-1];
          sdata_d   = shift_q[I2S_FRAME_BITS-1];
          shift_d   = shift_q << 1;
          if (wrap) begin
            shift_d = {slot_word(left_sample, SAMPLE_BITS), slot_word(right_sample, SAMPLE_BITS)};
            req_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= CNT_LAST;
      shift_q   <= '0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      req_q     <= req_d;
    end
  end

  assign sample_req = req_q;
  assign busy       = run;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = sdata_q;

endmodule

// File: tb/tb_sublime_i2s_tx.sv
// tb/tb_sublime_i2s_tx.sv - randomized bench with an I2S receiver model and expected-frame scoreboard
module tb_sublime_i2s_tx;

  localparam int SB         = 24;
  localparam int FRAME_CLKS = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] left_sample = '0;
  logic [31:0] right_sample = '0;
  logic        sample_req, busy, i2s_bclk, i2s_lrclk, i2s_sdata;

  sublime_i2s_tx #(.CLK_DIV(2), .SAMPLE_BITS(SB)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_req   (sample_req),
    .busy         (busy),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
  } frame_t;

  frame_t exp_q[$];
  bit     rand_mode = 1'b0;
  int     req_seen  = 0;
  int     words_ok  = 0;

  function automatic logic [31:0] slot_of(input logic [31:0] s);
    return (s >> (32 - SB)) << (32 - SB);
  endfunction

  // One clk step; a visible request means the samples currently applied were just captured.
  task automatic tick();
    frame_t f;
    @(posedge clk);
    #2;
    if (sample_req) begin
      req_seen++;
      f.l = slot_of(left_sample);
      f.r = slot_of(right_sample);
      exp_q.push_back(f);
      if (rand_mode) begin
        left_sample  = $urandom;
        right_sample = $urandom;
      end
    end
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!sample_req && n < 400);
    check_eq("req_timeout", 64'(sample_req), 64'(1));
  endtask

  task automatic start_check(input logic [31:0] l, input logic [31:0] r);
    left_sample  = l;
    right_sample = r;
    enable       = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_eq($sformatf("start_req_clk%0d", i), 64'(sample_req), 64'(i == 5));
      if (i == 1) check_eq("start_busy", 64'(busy), 64'(1));
    end
  endtask

  task automatic stop_check();
    int n;
    int req0;
    n = 0;
    repeat (40) begin
      tick();
      n++;
    end
    enable = 1'b0;
    req0   = req_seen;
    while (busy && n < 600) begin
      tick();
      n++;
    end
    check_eq("stop_at_wrap_clks", 64'(n), 64'(FRAME_CLKS));
    check_eq("stop_no_req", 64'(req_seen), 64'(req0));
    check_eq("stop_outputs", 64'({busy, i2s_bclk, i2s_lrclk, i2s_sdata}), 64'(0));
  endtask

  // Receiver model: shift in on BCLK rise, a word completes on the rise where LRCLK changes.
  int          cyc = 0;
  logic        prev_bclk = 0, prev_lr = 0, prev_sdata = 0, prev_busy = 0;
  logic [31:0] rx_word = '0;
  int          rx_n = 0;
  logic        rx_lr = 1'b0;
  int          last_req = 0, last_lr = 0;
  bit          have_req = 0, have_lr = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_q.delete();
      rx_n = 0; rx_word = '0; rx_lr = 1'b0; have_req = 0; have_lr = 0;
    end else begin
      if (i2s_sdata !== prev_sdata) check_eq("sdata_on_fall", 64'({prev_bclk, i2s_bclk}), 64'(2'b10));
      if (i2s_lrclk !== prev_lr) check_eq("lrclk_on_fall", 64'({prev_bclk, i2s_bclk}), 64'(2'b10));
      if (prev_busy && !busy) begin
        check_eq("stop_pending_frames", 64'(exp_q.size()), 64'(1));
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (!busy) begin
        rx_n = 0; rx_lr = 1'b0; have_req = 0; have_lr = 0;
      end
      if (sample_req) begin
        if (have_req) check_eq("req_spacing", 64'(cyc - last_req), 64'(FRAME_CLKS));
        last_req = cyc;
        have_req = 1;
      end
      if (!prev_bclk && i2s_bclk) begin
        rx_word = {rx_word[30:0], i2s_sdata};
        rx_n++;
        if (i2s_lrclk != rx_lr) begin
          if (rx_n >= 32) begin
            check_eq("rx_expected_frame", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
              if (!rx_lr) begin
                check_eq("rx_left", 64'(rx_word), 64'(exp_q[0].l));
              end else begin
                check_eq("rx_right", 64'(rx_word), 64'(exp_q[0].r));
                void'(exp_q.pop_front());
              end
              words_ok++;
            end
          end
          if (i2s_lrclk) begin
            if (have_lr) check_eq("lrclk_period", 64'(cyc - last_lr), 64'(FRAME_CLKS));
            last_lr = cyc;
            have_lr = 1;
          end
          rx_n  = 0;
          rx_lr = i2s_lrclk;
        end
      end
    end
    prev_bclk  = i2s_bclk;
    prev_lr    = i2s_lrclk;
    prev_sdata = i2s_sdata;
    prev_busy  = busy;
  end

  initial begin
    int bad;
    #3 rst = 1'b0;
    #2 check_eq("reset_outputs", 64'({sample_req, busy, i2s_bclk, i2s_lrclk, i2s_sdata}), 64'(0));
    repeat (3) tick();
    rst = 1'b1;

    // Reset mid-frame clears everything asynchronously, then idle stays quiet.
    left_sample  = $urandom;
    right_sample = 32'hFFFF_FFFF;
    enable       = 1'b1;
    repeat (150) tick();
    #1 rst = 1'b0;
    #1 check_eq("reset_async", 64'({sample_req, busy, i2s_bclk, i2s_lrclk, i2s_sdata}), 64'(0));
    enable = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    bad = 0;
    repeat (1000) begin
      tick();
      if ({sample_req, busy, i2s_bclk, i2s_lrclk, i2s_sdata} != 5'd0) bad++;
    end
    check_eq("idle_1000_quiet", 64'(bad), 64'(0));

    // Start latency and known pattern, then truncation/padding pattern, then random cadence.
    start_check(32'h1234_5600, 32'hABCD_EF00);
    left_sample  = 32'h0000_00FF;
    right_sample = 32'h8000_0001;
    wait_req();
    left_sample  = $urandom;
    right_sample = $urandom;
    rand_mode    = 1'b1;
    repeat (30) wait_req();

    stop_check();
    rand_mode = 1'b0;
    repeat (600) tick();
    check_eq("idle_after_stop", 64'({busy, sample_req, i2s_bclk}), 64'(0));

    // Restart, then a long randomized run for the edge/timing checks.
    start_check(32'h1234_5600, 32'hABCD_EF00);
    left_sample  = $urandom;
    right_sample = $urandom;
    rand_mode    = 1'b1;
    repeat (100) wait_req();
    stop_check();

    check_eq("words_decoded_enough", 64'(words_ok >= 200), 64'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
